// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction fetch unit.
package ifu_pkg;

    localparam logic [31:0] INST_NOP   = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic [31:0] INST_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_queue.sv
// Prefetch queue: allocates in issue order, fills in response order, pops from the head.
module ifu_queue
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alloc,
    input  logic [31:0]                alloc_addr,
    input  logic                       fill,
    input  logic [31:0]                fill_data,
    input  logic                       pop,
    output logic                       head_valid,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t     entries [DEPTH];
    logic [DEPTH-1:0] filled;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    fill_ptr;
    logic [PW-1:0]    rd_ptr;

    // NOTE: entry storage has no reset; it is only observed through filled/count, which are reset.
    always_ff @(posedge clk) begin
        if (alloc) entries[wr_ptr].addr <= alloc_addr;
        if (fill)  entries[fill_ptr].data <= fill_data;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pending  <= '0;
            filled   <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pending  <= '0;
            filled   <= '0;
        end else begin
            // The alloc slot is free, the fill slot is unfilled and the head is filled,
            // so these three indices never collide in one cycle.
            if (alloc) begin
                wr_ptr         <= wr_ptr + 1'b1;
                filled[wr_ptr] <= 1'b0;
            end
            if (fill) begin
                fill_ptr         <= fill_ptr + 1'b1;
                filled[fill_ptr] <= 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count   <= count + CW'(alloc) - CW'(pop);
            pending <= pending + CW'(alloc) - CW'(fill);
        end
    end

    assign head_valid = (count != '0) && filled[rd_ptr];
    assign head       = entries[rd_ptr];

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues in-order ROM reads, drops stale responses after a redirect.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc_q;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_d;
    logic [CW-1:0] count;
    logic [CW-1:0] pending;
    logic [CW:0]   occupancy;
    logic          issue;
    logic          fill;
    logic          pop;
    logic          head_valid;
    fetch_entry_t  head;

    // Issue looks only at registered occupancy, never at this cycle's pop or hold.
    assign occupancy  = {1'b0, count} + {1'b0, drop_cnt};
    assign mem_req_o  = !jump_en_i && (occupancy < (CW+1)'(DEPTH));
    assign mem_addr_o = pc_q;
    assign issue      = mem_req_o && mem_gnt_i;

    assign fill = mem_rvalid_i && (drop_cnt == '0) && (pending != '0) && !jump_en_i;
    assign pop  = head_valid && !hold_i && !jump_en_i;

    // NOTE: combinational blocks assign a default first so no path leaves drop_d unassigned (no latch).
    always_comb begin
        drop_d = drop_cnt;
        if (jump_en_i) begin
            // Every unfilled entry becomes a stale response; one arriving now is already paid off.
            drop_d = drop_cnt + pending;
            if (mem_rvalid_i && (drop_d != '0)) drop_d = drop_d - 1'b1;
        end else if (mem_rvalid_i && (drop_cnt != '0)) begin
            drop_d = drop_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            if (jump_en_i)  pc_q <= jump_addr_i;
            else if (issue) pc_q <= pc_q + INST_BYTES;
            drop_cnt <= drop_d;
        end
    end

    ifu_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (jump_en_i),
        .alloc      (issue),
        .alloc_addr (pc_q),
        .fill       (fill),
        .fill_data  (mem_rdata_i),
        .pop        (pop),
        .head_valid (head_valid),
        .head       (head),
        .count      (count),
        .pending    (pending)
    );

    assign inst_valid_o = head_valid;
    assign inst_o       = head_valid ? head.data : INST_NOP;
    assign inst_addr_o  = head_valid ? head.addr : ZERO_WORD;

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the 5-stage RV32I core. It owns the program counter and issues in-order read requests to the instruction ROM over a request/grant/response-valid handshake. Returned instruction words are buffered in a small prefetch queue and presented, with their addresses, to the if_id pipeline register. On a redirect from the execute stage it discards all queued and in-flight fetches.

## Interface
Parameters:
- `RESET_PC`, 32'h0, first fetch address after reset
- `DEPTH`, 4, prefetch queue entries; power of two, ≥2

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-low reset
- `jump_en_i`  in  1  redirect request from ex
- `jump_addr_i`  in  32  redirect target, word-aligned
- `hold_i`  in  1  downstream stall; head entry is not consumed
- `mem_req_o`  out  1  fetch request
- `mem_addr_o`  out  32  fetch address
- `mem_gnt_i`  in  1  request accepted this cycle
- `mem_rvalid_i`  in  1  response valid; responses return in request order, ≥1 cycle after grant
- `mem_rdata_i`  in  32  response data
- `inst_valid_o`  out  1  head entry holds a returned instruction
- `inst_o`  out  32  head instruction; `INST_NOP` when `inst_valid_o`=0
- `inst_addr_o`  out  32  head address; 0 when `inst_valid_o`=0

## Operation
- State: `pc_q`; circular queue of DEPTH entries {addr, data, filled}; `wr_ptr`/`fill_ptr`/`rd_ptr`; `count` (allocated entries, 0..DEPTH); `drop_cnt` (stale responses still owed, 0..DEPTH).
- Issue: `mem_req_o` = !jump_en_i && (count + drop_cnt < DEPTH); `mem_addr_o` = `pc_q`. On req&&gnt: allocate entry at `wr_ptr` with addr=`pc_q`, filled=0; `pc_q` += 4 (wraps mod 2^32).
- Response: on `mem_rvalid_i`, if `drop_cnt`>0 decrement it and discard data; else write data into the entry at `fill_ptr`, set filled, advance `fill_ptr`.
- Output: combinational from the `rd_ptr` entry; `inst_valid_o` = count>0 && filled.
- Pop: on `inst_valid_o` && !hold_i, free the head and advance `rd_ptr`.
- Redirect (`jump_en_i`=1): `pc_q` ← `jump_addr_i`; all entries freed, count←0, pointers reset to 0; `drop_cnt` ← drop_cnt + (allocated-unfilled entries) − (1 if a response arrives this cycle). No request this cycle; the pop is suppressed. Redirect wins over hold, pop and fill.
- Protocol violation: `mem_rvalid_i` with no unfilled entry and `drop_cnt`=0 is ignored; bench asserts on it.

## Timing
- Reset (rst=0, asynchronous): `pc_q`=RESET_PC, count=0, drop_cnt=0, all pointers 0. Outputs: `mem_req_o`=1 (once `jump_en_i`=0), `mem_addr_o`=RESET_PC, `inst_valid_o`=0, `inst_o`=`INST_NOP`, `inst_addr_o`=0. ROM shares `rst`; no responses survive reset.
- Latency with same-cycle grant and 1-cycle response: request in cycle N, `inst_valid_o` in cycle N+2.
- Throughput: one instruction per cycle for DEPTH≥3 with a 1-cycle ROM. Issue does not depend on the same-cycle pop, so `hold_i` has no combinational path to `mem_req_o`.
- Full: count+drop_cnt=DEPTH → `mem_req_o`=0 until a pop or stale response.
- Empty, or head not filled → `inst_valid_o`=0.
- First post-redirect request is issued in the cycle after `jump_en_i`. Its instruction reaches the output only after all owed stale responses have drained.

## Structure
- `defines.v` gains `INST_NOP` (32'h00000013). The existing `ZeroWord` covers the zero outputs.
- One sub-module is natural: `ifu_queue`, holding the entry storage, pointers, count and filled flags. `ifu` keeps `pc_q`, `drop_cnt` and the issue/redirect logic.

## Test plan
- Reset release, ROM grants every cycle, 1-cycle rvalid → requests at 0x0,0x4,0x8…; `inst_valid_o` first high 2 cycles after release with `inst_addr_o`=0x0; then one instruction per cycle.
- `hold_i`=1 for 6 cycles → head stays at the same addr/data; `mem_req_o` falls once count=4; sequence resumes with no gap or duplicate.
- Redirect to 0x100 while 2 responses are in flight → `drop_cnt`=2, both stale words discarded; next `inst_valid_o` shows `inst_addr_o`=0x100.
- Redirect in the same cycle as a response and a pop → the response counts against `drop_cnt`; no entry is popped or filled; the new fetch starts the next cycle.
- ROM with 3-cycle latency and random grant stalls → addresses remain strictly sequential; count+drop_cnt never exceeds DEPTH.
- `rst` asserted mid-stream with a full queue → outputs return to reset values immediately; the first request after release is RESET_PC.
